// File: rtl/tri_bus_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
// The owner index width is fixed at 3 bits so that it covers up to 8 devices.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    localparam int OWNER_W = 3;

    // Width of a saturating counter that must be able to hold the value max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It returns the first requester found at or after ptr_i, wrapping from the highest index back to 0.
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N_DEV = 2
) (
    input  logic [N_DEV-1:0]   req_i,
    input  logic [OWNER_W-1:0] ptr_i,
    output logic [N_DEV-1:0]   win_oh_o,
    output logic [OWNER_W-1:0] win_idx_o,
    output logic               any_req_o
);

    int best_d_s;
    int dist_s;

    // The winner is the requester with the smallest circular distance from the pointer.
    always_comb begin
        best_d_s  = N_DEV;
        dist_s    = 0;
        win_idx_o = '0;
        for (int j = 0; j < N_DEV; j++) begin
            dist_s = j - int'(ptr_i);
            if (dist_s < 0) begin
                dist_s = dist_s + N_DEV;
            end else begin
                dist_s = dist_s;
            end
            if (req_i[j] && (dist_s < best_d_s)) begin
                best_d_s  = dist_s;
                win_idx_o = OWNER_W'(j);
            end else begin
                best_d_s  = best_d_s;
            end
        end
    end

    // The one-hot grant vector is derived from the winner index.
    always_comb begin
        any_req_o = |req_i;
        win_oh_o  = '0;
        for (int j = 0; j < N_DEV; j++) begin
            win_oh_o[j] = any_req_o && (win_idx_o == OWNER_W'(j));
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus. The bus hold time is bounded,
// and one undriven turnaround cycle is inserted between owners.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_DEV    = 2,
    parameter int DW       = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_DEV-1:0]      req,
    input  logic [N_DEV*DW-1:0]   dev_data,
    output logic [N_DEV-1:0]      gnt,
    output logic [N_DEV-1:0]      dev_oe,
    output tri   [DW-1:0]         bus,
    output logic                  bus_valid,
    output logic [OWNER_W-1:0]    owner
);

    localparam int            HW       = cnt_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    state_e               state_q;
    logic [N_DEV-1:0]     gnt_q;
    logic                 valid_q;
    logic [OWNER_W-1:0]   owner_q;
    logic [OWNER_W-1:0]   rr_ptr_q;
    logic [HW-1:0]        hold_q;

    logic [OWNER_W-1:0]   rr_ptr_d;
    logic [N_DEV-1:0]     win_oh_s;
    logic [OWNER_W-1:0]   win_idx_s;
    logic                 any_s;
    logic                 owner_req_s;
    logic                 leave_s;
    logic [DW-1:0]        sel_s;

    rr_pick #(
        .N_DEV (N_DEV)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .win_oh_o  (win_oh_s),
        .win_idx_o (win_idx_s),
        .any_req_o (any_s)
    );

    // The owner's request is taken from the one-hot grant. This avoids indexing req with the owner index.
    always_comb begin
        owner_req_s = |(req & gnt_q);
        leave_s     = (!owner_req_s) || (hold_q == HOLD_MAX);
        if (owner_q == OWNER_W'(N_DEV - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = owner_q + OWNER_W'(1);
        end
    end

    // Selects the data slice of the owner.
    always_comb begin
        sel_s = '0;
        for (int j = 0; j < N_DEV; j++) begin
            if (owner_q == OWNER_W'(j)) begin
                sel_s = dev_data[j*DW +: DW];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Arbitration FSM. Grant, valid, owner, pointer and hold counter are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_TURN: begin
                    if (any_s) begin
                        state_q <= ST_OWN;
                        gnt_q   <= win_oh_s;
                        owner_q <= win_idx_s;
                        hold_q  <= HW'(1);
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (leave_s) begin
                        state_q  <= ST_TURN;
                        gnt_q    <= '0;
                        valid_q  <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q   <= hold_q + HW'(1);
                    end else begin
                        hold_q   <= hold_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign dev_oe    = gnt_q;
    assign bus_valid = valid_q;
    assign owner     = owner_q;
    assign bus       = valid_q ? sel_s : {DW{1'bz}};

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter. A high-level model of ownership, hold and turnaround
// is compared against the DUT on every cycle, and literal sequences pin the model itself.
module tb_tri_bus_arbiter;
    localparam int N_DEV    = 2;
    localparam int DW       = 2;
    localparam int MAX_HOLD = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_DEV-1:0]    req;
    logic [N_DEV*DW-1:0] dev_data;
    logic [N_DEV-1:0]    gnt;
    logic [N_DEV-1:0]    dev_oe;
    wire  [DW-1:0]       bus_w;
    logic                bus_valid;
    logic [2:0]          owner;

    int checks   = 0;
    int failures = 0;

    // Model state: the owner index, or -1 when the bus is free.
    int m_owner;
    int m_last;
    int m_hold;
    int m_ptr;
    bit m_turn;

    // An undriven bus reads as all ones.
    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup (bus_w[g]);
    end

    always #5 clk = ~clk;

    tri_bus_arbiter #(.N_DEV(N_DEV), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .dev_data(dev_data), .gnt(gnt),
        .dev_oe(dev_oe), .bus(bus_w), .bus_valid(bus_valid), .owner(owner)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_hold = 0; m_ptr = 0; m_turn = 1'b0;
    endtask

    task automatic model_grant(input logic [N_DEV-1:0] r);
        for (int k = 0; k < N_DEV; k++) begin
            int d;
            d = (m_ptr + k) % N_DEV;
            if (r[d] && m_owner < 0) begin
                m_owner = d; m_last = d; m_hold = 1;
            end
        end
    endtask

    task automatic model_step(input logic [N_DEV-1:0] r);
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_hold == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % N_DEV;
                m_owner = -1;
                m_turn = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            m_turn = 1'b0;
            model_grant(r);
        end
    endtask

    task automatic compare_all();
        logic [N_DEV-1:0] eg;
        logic [DW-1:0]    eb;
        eg = (m_owner >= 0) ? N_DEV'(1 << m_owner) : '0;
        eb = (m_owner >= 0) ? dev_data[m_owner*DW +: DW] : {DW{1'b1}};
        chk("gnt", 32'(gnt), 32'(eg));
        chk("dev_oe", 32'(dev_oe), 32'(eg));
        chk("bus_valid", 32'(bus_valid), 32'(m_owner >= 0));
        chk("owner", 32'(owner), 32'(m_last));
        chk("bus", 32'(bus_w), 32'(eb));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(req);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    logic [1:0] exp3 [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0] exp4 [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [1:0] expb [11] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};

    initial begin
        rst = 1'b1; req = '0; dev_data = '0;
        model_reset();
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_valid", 32'(bus_valid), 32'd0);
        do_reset();

        // A single owner drops its request, then the arbiter passes through turnaround to idle.
        req = 2'b01; dev_data = 4'b0011;
        cycle();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_bus", 32'(bus_w), 32'h3);
        dev_data = 4'b0001;
        #1 chk("bus_comb", 32'(bus_w), 32'h1);
        req = 2'b00;
        cycle();
        chk("single_turn_valid", 32'(bus_valid), 32'd0);
        cycle();
        chk("single_idle_gnt", 32'(gnt), 32'd0);

        // A lone requester is limited by the hold time.
        req = 2'b01; dev_data = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("hold_seq", 32'(gnt), 32'(exp3[i]));
        end
        req = 2'b00;
        cycle(); cycle();

        // Both devices request on the same edge after reset; the two owners alternate.
        do_reset();
        req = 2'b11; dev_data = 4'b1011;
        for (int i = 0; i < 11; i++) begin
            cycle();
            chk("rr_gnt", 32'(gnt), 32'(exp4[i]));
            chk("rr_bus", 32'(bus_w), 32'(expb[i]));
        end

        // An asynchronous reset while the bus is owned releases it immediately.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_oe", 32'(dev_oe), 32'd0);
        chk("async_rst_valid", 32'(bus_valid), 32'd0);
        chk("async_rst_bus", 32'(bus_w), 32'h3);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with sticky requests.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < N_DEV; d++) begin
                if ($urandom_range(0, 3) == 0) req[d] = ~req[d];
            end
            dev_data = N_DEV*DW'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
